// File: rtl/otter_bus_pkg.sv
// Shared bus definitions: demux state encoding, default MMIO window base and
// the read data returned when an MMIO access times out.
package otter_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAM_RD    = 2'd1,
        ST_MMIO_WAIT = 2'd2,
        ST_MMIO_RESP = 2'd3
    } bus_state_t;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h1100_0000;
    localparam logic [31:0] TIMEOUT_DATA      = 32'hDEAD_BEEF;

    function automatic logic addr_is_mmio(input logic [31:0] addr, input logic [31:0] base);
        return (addr >= base);
    endfunction

endpackage

// File: rtl/mem_bus_demux.sv
// Routes one initiator to a single-cycle RAM port or a handshaked MMIO port.
// Optional MMIO watchdog enabled by defining MEM_BUS_DEMUX_TIMEOUT_EN.
module mem_bus_demux
    import otter_bus_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE      = DEFAULT_MMIO_BASE,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic        i_re,
    input  logic        i_we,
    output logic [31:0] i_rdata,
    output logic        i_rvalid,
    output logic        i_busy,
    output logic [31:0] r_addr,
    output logic [31:0] r_wdata,
    output logic [1:0]  r_size,
    output logic        r_re,
    output logic        r_we,
    input  logic [31:0] r_rdata,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_size,
    output logic        m_re,
    output logic        m_we,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        err
);

    bus_state_t  state_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  size_reg;
    logic        re_reg;
    logic        we_reg;
    logic [31:0] resp_data_reg;

    logic accept;
    logic to_mmio;
    logic is_read;

    // A write wins when both strobes are high; strobes are also gated by reset
    // so nothing leaks onto either target while rst_n is held low.
    assign is_read = i_re & ~i_we;
    assign accept  = rst_n & (i_re | i_we) & (state_reg != ST_MMIO_WAIT);
    assign to_mmio = addr_is_mmio(i_addr, MMIO_BASE);

    assign r_addr  = i_addr;
    assign r_wdata = i_wdata;
    assign r_size  = i_size;
    assign r_re    = accept & ~to_mmio & is_read;
    assign r_we    = accept & ~to_mmio & i_we;

    assign m_addr  = addr_reg;
    assign m_wdata = wdata_reg;
    assign m_size  = size_reg;
    assign m_re    = (state_reg == ST_MMIO_WAIT) & re_reg;
    assign m_we    = (state_reg == ST_MMIO_WAIT) & we_reg;

    assign i_busy   = (state_reg == ST_MMIO_WAIT);
    assign i_rvalid = (state_reg == ST_RAM_RD) | (state_reg == ST_MMIO_RESP);

    always_comb begin
        i_rdata = 32'h0;
        if (state_reg == ST_RAM_RD)
            i_rdata = r_rdata;
        else if (state_reg == ST_MMIO_RESP)
            i_rdata = resp_data_reg;
    end

`ifdef MEM_BUS_DEMUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_reg;
    logic             err_reg;

    assign err = err_reg;
`else
    assign err = 1'b0;

    // Keeps the watchdog length parameter referenced when the watchdog is absent.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= 32'h0;
            wdata_reg     <= 32'h0;
            size_reg      <= 2'b00;
            re_reg        <= 1'b0;
            we_reg        <= 1'b0;
            resp_data_reg <= 32'h0;
`ifdef MEM_BUS_DEMUX_TIMEOUT_EN
            tmo_cnt_reg   <= '0;
            err_reg       <= 1'b0;
`endif
        end else begin
`ifdef MEM_BUS_DEMUX_TIMEOUT_EN
            err_reg <= 1'b0;
`endif
            if (state_reg == ST_MMIO_WAIT) begin
                // An ack in the expiry cycle takes precedence over the watchdog.
                if (m_ack) begin
                    if (we_reg) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        resp_data_reg <= m_rdata;
                        state_reg     <= ST_MMIO_RESP;
                    end
                end
`ifdef MEM_BUS_DEMUX_TIMEOUT_EN
                else if (tmo_cnt_reg == CNT_LAST) begin
                    err_reg <= 1'b1;
                    if (we_reg) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        resp_data_reg <= TIMEOUT_DATA;
                        state_reg     <= ST_MMIO_RESP;
                    end
                end else begin
                    tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                end
`endif
            end else if (accept) begin
                if (to_mmio) begin
                    addr_reg  <= i_addr;
                    wdata_reg <= i_wdata;
                    size_reg  <= i_size;
                    re_reg    <= is_read;
                    we_reg    <= i_we;
                    state_reg <= ST_MMIO_WAIT;
`ifdef MEM_BUS_DEMUX_TIMEOUT_EN
                    tmo_cnt_reg <= '0;
`endif
                end else begin
                    state_reg <= is_read ? ST_RAM_RD : ST_IDLE;
                end
            end else begin
                state_reg <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_demux.sv
// Directed bench for mem_bus_demux: expected read responses are queued by the
// stimulus and consumed by an independent monitor on every falling edge.
module tb_mem_bus_demux;

    logic        clk;
    logic        rst_n;
    logic [31:0] i_addr, i_wdata, i_rdata;
    logic [1:0]  i_size;
    logic        i_re, i_we, i_rvalid, i_busy;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [1:0]  r_size;
    logic        r_re, r_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_size;
    logic        m_re, m_we, m_ack;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ram[logic [31:0]];

    mem_bus_demux #(
        .MMIO_BASE     (32'h1100_0000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_addr  (i_addr),
        .i_wdata (i_wdata),
        .i_size  (i_size),
        .i_re    (i_re),
        .i_we    (i_we),
        .i_rdata (i_rdata),
        .i_rvalid(i_rvalid),
        .i_busy  (i_busy),
        .r_addr  (r_addr),
        .r_wdata (r_wdata),
        .r_size  (r_size),
        .r_re    (r_re),
        .r_we    (r_we),
        .r_rdata (r_rdata),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_size  (m_size),
        .m_re    (m_re),
        .m_we    (m_we),
        .m_rdata (m_rdata),
        .m_ack   (m_ack),
        .err     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle RAM: data appears the cycle after r_re.
    always @(posedge clk) begin
        if (r_re)
            r_rdata <= ram.exists(r_addr) ? ram[r_addr] : 32'h0;
    end

    always @(negedge clk) begin
        if (i_rvalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", {31'h0, i_rvalid}, 32'h0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("rdata", i_rdata, e);
                $display("resp rdata=%h expected=%h", i_rdata, e);
            end
        end else begin
            check("rdata_idle_zero", i_rdata, 32'h0);
        end
    end

    initial begin
        ram[32'h0000_0100] = 32'h1234_5678;
        ram[32'h0000_0104] = 32'hCAFE_F00D;
        ram[32'h10FF_FFFC] = 32'h0BAD_F00D;
        r_rdata = 32'h0;
        rst_n = 1'b0;
        i_addr = 32'h100; i_wdata = 32'h0; i_size = 2'd2; i_re = 1'b1; i_we = 1'b0;
        m_rdata = 32'h0; m_ack = 1'b0;

        #3;
        check("rst_r_re", {31'h0, r_re}, 32'h0);
        check("rst_busy", {31'h0, i_busy}, 32'h0);
        check("rst_rvalid", {31'h0, i_rvalid}, 32'h0);
        check("rst_m_re", {31'h0, m_re}, 32'h0);
        check("rst_m_addr", m_addr, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        i_re = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single RAM read
        cyc(); i_re = 1'b1; i_addr = 32'h100; exp_q.push_back(32'h1234_5678);
        $display("req ram read addr=00000100");
        @(negedge clk);
        check("ram_rd_r_re", {31'h0, r_re}, 32'h1);
        check("ram_rd_r_addr", r_addr, 32'h100);
        check("ram_rd_busy", {31'h0, i_busy}, 32'h0);
        cyc(); i_re = 1'b0;
        @(negedge clk);
        check("ram_rd_busy2", {31'h0, i_busy}, 32'h0);

        // Back-to-back RAM reads
        cyc(); i_re = 1'b1; i_addr = 32'h100; exp_q.push_back(32'h1234_5678);
        $display("req ram read addr=00000100");
        cyc(); i_addr = 32'h104; exp_q.push_back(32'hCAFE_F00D);
        $display("req ram read addr=00000104");
        @(negedge clk);
        check("b2b_r_re", {31'h0, r_re}, 32'h1);
        cyc(); i_re = 1'b0;
        @(negedge clk);
        check("b2b_second_pulse", {31'h0, i_rvalid}, 32'h1);
        cyc();

        // RAM write
        i_we = 1'b1; i_addr = 32'h40; i_wdata = 32'h77;
        $display("req ram write addr=00000040 data=00000077");
        @(negedge clk);
        check("ram_wr_r_we", {31'h0, r_we}, 32'h1);
        check("ram_wr_r_wdata", r_wdata, 32'h77);
        check("ram_wr_r_re", {31'h0, r_re}, 32'h0);
        cyc(); i_we = 1'b0;

        // Both strobes: write, no response
        cyc(); i_re = 1'b1; i_we = 1'b1; i_addr = 32'h80;
        $display("req ram read+write addr=00000080");
        @(negedge clk);
        check("both_r_we", {31'h0, r_we}, 32'h1);
        check("both_r_re", {31'h0, r_re}, 32'h0);
        cyc(); i_re = 1'b0; i_we = 1'b0;

        // Boundary: last RAM word below MMIO window
        cyc(); i_re = 1'b1; i_addr = 32'h10FF_FFFC; exp_q.push_back(32'h0BAD_F00D);
        $display("req ram read addr=10fffffc");
        @(negedge clk);
        check("bnd_ram_r_re", {31'h0, r_re}, 32'h1);
        cyc(); i_re = 1'b0;
        @(negedge clk);
        check("bnd_ram_busy", {31'h0, i_busy}, 32'h0);
        check("bnd_ram_m_re", {31'h0, m_re}, 32'h0);

        // MMIO write at MMIO_BASE, ack in third wait cycle
        cyc(); i_we = 1'b1; i_addr = 32'h1100_0000; i_wdata = 32'hA5;
        $display("req mmio write addr=11000000 data=000000a5");
        @(negedge clk);
        check("mmio_wr_r_we", {31'h0, r_we}, 32'h0);
        check("mmio_wr_m_we_accept", {31'h0, m_we}, 32'h0);
        for (int w = 0; w < 3; w++) begin
            cyc(); i_we = 1'b0; m_ack = (w == 2);
            @(negedge clk);
            check("mmio_wr_m_we", {31'h0, m_we}, 32'h1);
            check("mmio_wr_busy", {31'h0, i_busy}, 32'h1);
            check("mmio_wr_m_addr", m_addr, 32'h1100_0000);
            check("mmio_wr_m_wdata", m_wdata, 32'hA5);
        end
        cyc(); m_ack = 1'b0;
        @(negedge clk);
        check("mmio_wr_done_busy", {31'h0, i_busy}, 32'h0);
        check("mmio_wr_done_m_we", {31'h0, m_we}, 32'h0);

        // MMIO read; request during busy is ignored; RAM read accepted in MMIO_RESP
        cyc(); i_re = 1'b1; i_addr = 32'h1100_0010; exp_q.push_back(32'h55);
        $display("req mmio read addr=11000010");
        @(negedge clk);
        check("mmio_rd_r_re", {31'h0, r_re}, 32'h0);
        cyc(); i_addr = 32'h200;
        $display("req ram read addr=00000200 during busy");
        @(negedge clk);
        check("ignored_busy", {31'h0, i_busy}, 32'h1);
        check("ignored_r_re", {31'h0, r_re}, 32'h0);
        check("mmio_rd_m_re", {31'h0, m_re}, 32'h1);
        check("mmio_rd_m_addr", m_addr, 32'h1100_0010);
        cyc(); i_re = 1'b0; m_ack = 1'b1; m_rdata = 32'h55;
        @(negedge clk);
        check("mmio_rd_m_re_ack", {31'h0, m_re}, 32'h1);
        cyc(); m_ack = 1'b0; m_rdata = 32'h0;
        i_re = 1'b1; i_addr = 32'h104; exp_q.push_back(32'hCAFE_F00D);
        $display("req ram read addr=00000104 in mmio_resp");
        @(negedge clk);
        check("mmio_rd_resp_valid", {31'h0, i_rvalid}, 32'h1);
        check("mmio_rd_resp_busy", {31'h0, i_busy}, 32'h0);
        check("mmio_rd_err", {31'h0, err}, 32'h0);
        check("resp_accept_r_re", {31'h0, r_re}, 32'h1);
        cyc(); i_re = 1'b0;
        @(negedge clk);
        check("resp_accept_valid", {31'h0, i_rvalid}, 32'h1);

        // Reset in the middle of an MMIO wait
        cyc(); i_re = 1'b1; i_addr = 32'h1100_0020;
        $display("req mmio read addr=11000020 then reset");
        cyc(); i_re = 1'b0;
        @(negedge clk);
        check("rst_mid_busy_before", {31'h0, i_busy}, 32'h1);
        cyc(); rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'h0, i_busy}, 32'h0);
        check("rst_mid_m_re", {31'h0, m_re}, 32'h0);
        check("rst_mid_m_addr", m_addr, 32'h0);
        check("rst_mid_rvalid", {31'h0, i_rvalid}, 32'h0);
        cyc(); rst_n = 1'b1; m_ack = 1'b1; m_rdata = 32'h99;
        cyc(); m_ack = 1'b0; m_rdata = 32'h0;
        @(negedge clk);
        check("rst_mid_after_busy", {31'h0, i_busy}, 32'h0);

`ifdef MEM_BUS_DEMUX_TIMEOUT_EN
        // Unacknowledged MMIO read expires after four wait cycles
        cyc(); i_re = 1'b1; i_addr = 32'h1100_0030; exp_q.push_back(32'hDEAD_BEEF);
        $display("req mmio read addr=11000030 no ack");
        for (int w = 0; w < 4; w++) begin
            cyc(); i_re = 1'b0;
            @(negedge clk);
            check("tmo_wait_busy", {31'h0, i_busy}, 32'h1);
            check("tmo_wait_err", {31'h0, err}, 32'h0);
        end
        cyc();
        @(negedge clk);
        check("tmo_err", {31'h0, err}, 32'h1);
        check("tmo_rvalid", {31'h0, i_rvalid}, 32'h1);
        cyc();
        @(negedge clk);
        check("tmo_err_pulse", {31'h0, err}, 32'h0);
`endif

        repeat (3) cyc();
        check("queue_empty", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
